rcc_lsecss_mon: RTL and testbench



---
 rtl/rcc_lsecss_mon.sv | 209 ++++++++++++++++++++
 tb/tb_rcc_lsecss_mon.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rcc_lsecss_mon.sv
// ---------------------------------------------------------------------------
// rcc_lsecss_mon
//
// LSE clock security monitor. The raw LSE oscillator output is sampled as
// plain data on the always-running reference clock. The gap between
// successive LSE rising edges is measured in reference cycles. If the gap
// reaches TIMEOUT, the LSE is declared failed. The failure is a sticky level
// that only a reset clears.
//
// Ports:
//   clk          reference clock, the only clock of the block
//   rst_n        synchronous active-low reset (backup-domain reset)
//   lse_clk      raw LSE oscillator output, asynchronous, treated as data
//   lseon        LSE enable from the backup-domain register block
//   lsecsson     CSS enable from the backup-domain register block
//   lse_rdy      LSE ready from the oscillator
//   lsecss_fail  sticky failure level (high while in FAIL)
//   lsecss_int   one-cycle pulse in the first FAIL cycle
//   css_active   high while the monitor is actively checking edge gaps
// ---------------------------------------------------------------------------
module rcc_lsecss_mon #(
    parameter int CNT_W     = 8,
    parameter int TIMEOUT   = 200,
    parameter int ARM_EDGES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic lse_clk,
    input  logic lseon,
    input  logic lsecsson,
    input  logic lse_rdy,
    output logic lsecss_fail,
    output logic lsecss_int,
    output logic css_active
);

    localparam int EC_W = $clog2(ARM_EDGES + 1);

    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_MAX  = {CNT_W{1'b1}};
    localparam logic [EC_W-1:0]  EC_LAST  = EC_W'(ARM_EDGES - 1);
    localparam logic [EC_W-1:0]  EC_FULL  = EC_W'(ARM_EDGES);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_RDY = 3'd1,
        ST_ARM      = 3'd2,
        ST_MONITOR  = 3'd3,
        ST_FAIL     = 3'd4
    } state_t;

    // -----------------------------------------------------------------------
    // Control synchronizers: bit 0 = lseon, bit 1 = lsecsson, bit 2 = lse_rdy
    // -----------------------------------------------------------------------
    logic [2:0] ctl_in;
    logic [2:0] ctl_sync;

    assign ctl_in = {lse_rdy, lsecsson, lseon};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_ctl_sync
            logic meta_reg;
            logic sync_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= ctl_in[gi];
                    sync_reg <= meta_reg;
                end
            end

            assign ctl_sync[gi] = sync_reg;
        end
    endgenerate

    logic lseon_s;
    logic lsecsson_s;
    logic lse_rdy_s;

    assign lseon_s    = ctl_sync[0];
    assign lsecsson_s = ctl_sync[1];
    assign lse_rdy_s  = ctl_sync[2];

    // -----------------------------------------------------------------------
    // LSE synchronizer plus a third flop for rising-edge detection
    // -----------------------------------------------------------------------
    logic lse_meta_reg;
    logic lse_sync_reg;
    logic lse_prev_reg;
    logic lse_edge;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lse_meta_reg <= 1'b0;
            lse_sync_reg <= 1'b0;
            lse_prev_reg <= 1'b0;
        end else begin
            lse_meta_reg <= lse_clk;
            lse_sync_reg <= lse_meta_reg;
            lse_prev_reg <= lse_sync_reg;
        end
    end

    assign lse_edge = lse_sync_reg & ~lse_prev_reg;

    // -----------------------------------------------------------------------
    // State and counters
    // -----------------------------------------------------------------------
    state_t            state_reg;
    state_t            state_next;
    logic [CNT_W-1:0]  gap_reg;
    logic [CNT_W-1:0]  gap_next;
    logic [EC_W-1:0]   edge_cnt_reg;
    logic [EC_W-1:0]   edge_cnt_next;
    logic              int_done_reg;

    logic enabled;
    logic gap_expire;
    logic arm_done;
    logic counting;

    assign enabled  = lseon_s & lsecsson_s;
    assign counting = (state_reg == ST_ARM) || (state_reg == ST_MONITOR);

    // The last permitted cycle of the gap window. An edge arriving in this
    // very cycle still rescues the oscillator, so the edge has priority.
    assign gap_expire = (gap_reg == GAP_LAST) && !lse_edge;

    // The edge that brings the edge count up to ARM_EDGES completes arming.
    assign arm_done = lse_edge && (edge_cnt_reg == EC_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            gap_reg      <= '0;
            edge_cnt_reg <= '0;
            int_done_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            gap_reg      <= gap_next;
            edge_cnt_reg <= edge_cnt_next;
            // Remembers that the first FAIL cycle has already been seen,
            // so the interrupt pulse lasts exactly one cycle.
            int_done_reg <= (state_reg == ST_FAIL);
        end
    end

    // Next-state logic. Losing the enables takes priority over a timeout,
    // so a deliberate LSE shutdown is never reported as a failure.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (enabled) state_next = ST_WAIT_RDY;
            end
            ST_WAIT_RDY: begin
                if (!enabled)      state_next = ST_IDLE;
                else if (lse_rdy_s) state_next = ST_ARM;
            end
            ST_ARM: begin
                if (!enabled)        state_next = ST_IDLE;
                else if (arm_done)   state_next = ST_MONITOR;
                else if (gap_expire) state_next = ST_FAIL;
            end
            ST_MONITOR: begin
                if (!enabled)        state_next = ST_IDLE;
                else if (gap_expire) state_next = ST_FAIL;
            end
            ST_FAIL: begin
                state_next = ST_FAIL;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Counter datapath. The gap counter only runs while arming or monitoring
    // and saturates rather than wrapping. The edge count is only advanced
    // during arming and is held (saturated) in MONITOR.
    always_comb begin
        gap_next      = '0;
        edge_cnt_next = '0;
        if (counting) begin
            if (lse_edge)
                gap_next = '0;
            else if (gap_reg == GAP_MAX)
                gap_next = gap_reg;
            else
                gap_next = gap_reg + CNT_W'(1);

            edge_cnt_next = edge_cnt_reg;
            if ((state_reg == ST_ARM) && lse_edge && (edge_cnt_reg != EC_FULL))
                edge_cnt_next = edge_cnt_reg + EC_W'(1);
        end
    end

    // Output decode, from registered state only
    always_comb begin
        css_active  = (state_reg == ST_MONITOR);
        lsecss_fail = (state_reg == ST_FAIL);
        lsecss_int  = (state_reg == ST_FAIL) && !int_done_reg;
    end

endmodule

// File: tb/tb_rcc_lsecss_mon.sv
// ---------------------------------------------------------------------------
// tb_rcc_lsecss_mon
//
// Directed bench for rcc_lsecss_mon. A table of phases (inputs, LSE period,
// duration, expected outputs) covers reset, idle, waiting for ready, arming
// and deliberate disable. Hand-written sequences cover stop detection, the
// gap boundary, a stop during arming and reset out of FAIL.
//
// Timing model used for the expected values: the raw LSE rise is driven
// just after a clock edge. The gap counter is cleared on the third edge
// after that. The gap counter then reaches TIMEOUT-1 after TIMEOUT-1 more
// edges, and the block enters FAIL on the edge after that. So, counting
// the edge that first samples the rise as edge 1, lsecss_fail is first
// seen high after edge TIMEOUT+3.
// ---------------------------------------------------------------------------
module tb_rcc_lsecss_mon;

    localparam int TIMEOUT = 200;

    logic clk;
    logic rst_n;
    logic lse_clk;
    logic lseon;
    logic lsecsson;
    logic lse_rdy;
    logic lsecss_fail;
    logic lsecss_int;
    logic css_active;

    int checks = 0;
    int errors = 0;

    // LSE generator state: period 0 holds lse_clk at whatever was driven
    int gen_period = 0;
    int gen_phase  = 0;

    rcc_lsecss_mon #(
        .CNT_W    (8),
        .TIMEOUT  (TIMEOUT),
        .ARM_EDGES(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .lse_clk    (lse_clk),
        .lseon      (lseon),
        .lsecsson   (lsecsson),
        .lse_rdy    (lse_rdy),
        .lsecss_fail(lsecss_fail),
        .lsecss_int (lsecss_int),
        .css_active (css_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit rst_n;
        bit lseon;
        bit lsecsson;
        bit lse_rdy;
        int period;
        bit lse_lvl;
        bit restart;
        int ticks;
        bit chk_all;
        bit exp_fail;
        bit exp_int;
        bit exp_act;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    // One clock: advance the LSE generator, then sample #1 after the edge
    task automatic tick();
        if (gen_period != 0) begin
            lse_clk   = (gen_phase < gen_period / 2);
            gen_phase = (gen_phase + 1) % gen_period;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check3(input string tag, input logic ef, input logic ei, input logic ea);
        chk({tag, "_fail"},   lsecss_fail, ef);
        chk({tag, "_int"},    lsecss_int,  ei);
        chk({tag, "_active"}, css_active,  ea);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        lseon      = 1'b0;
        lsecsson   = 1'b0;
        lse_rdy    = 1'b0;
        lse_clk    = 1'b0;
        gen_period = 0;
        repeat (2) tick();
        check3("reset", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    // Bring the block into MONITOR using a 20-cycle LSE, then leave it there
    task automatic arm_monitor(input string tag);
        do_reset();
        lseon      = 1'b1;
        lsecsson   = 1'b1;
        lse_rdy    = 1'b1;
        lse_clk    = 1'b0;
        gen_period = 0;
        repeat (4) tick();
        gen_phase  = 0;
        gen_period = 20;
        repeat (80) tick();
        check3(tag, 1'b0, 1'b0, 1'b1);
    endtask

    // Boundary: from MONITOR, a fresh LSE with the given period
    task automatic boundary(input int p);
        string tag;
        bit exp_f;
        tag = $sformatf("bnd%0d", p);
        arm_monitor({tag, "_arm"});
        gen_period = 0;
        lse_clk    = 1'b0;
        repeat (10) tick();
        gen_phase  = 0;
        gen_period = p;
        for (int i = 1; i <= 650; i++) begin
            tick();
            exp_f = (p > TIMEOUT) && (i >= TIMEOUT + 3);
            chk($sformatf("%s_fail_t%0d", tag, i), lsecss_fail, exp_f);
            chk($sformatf("%s_active_t%0d", tag, i), css_active, !exp_f);
        end
        $display("boundary period %0d: fail=%b active=%b", p, lsecss_fail, css_active);
    endtask

    initial begin
        rst_n    = 1'b0;
        lseon    = 1'b0;
        lsecsson = 1'b0;
        lse_rdy  = 1'b0;
        lse_clk  = 1'b0;

        //          rst lon css rdy per lvl rst  ticks  all  f  i  a
        vecs[0] = '{0,  0,  0,  0,  0,  0,  0,   2,     1,   0, 0, 0}; // in reset
        vecs[1] = '{1,  0,  0,  0,  20, 0,  1,   1000,  1,   0, 0, 0}; // idle, LSE toggling
        vecs[2] = '{1,  1,  1,  0,  0,  0,  0,   400,   1,   0, 0, 0}; // WAIT_RDY, no timeout
        vecs[3] = '{1,  1,  1,  1,  0,  0,  0,   4,     1,   0, 0, 0}; // into ARM
        vecs[4] = '{1,  1,  1,  1,  20, 0,  1,   62,    1,   0, 0, 0}; // 4 edges, not yet synced
        vecs[5] = '{1,  1,  1,  1,  20, 0,  0,   1,     0,   0, 0, 1}; // 4th lse_edge -> MONITOR
        vecs[6] = '{1,  1,  1,  1,  20, 0,  0,   10000, 1,   0, 0, 1}; // steady monitoring
        vecs[7] = '{1,  0,  1,  1,  0,  0,  0,   2,     0,   0, 0, 1}; // lseon drop in sync
        vecs[8] = '{1,  0,  1,  1,  0,  0,  0,   1,     0,   0, 0, 0}; // back to IDLE
        vecs[9] = '{1,  0,  1,  1,  0,  0,  0,   300,   1,   0, 0, 0}; // stopped, no fail

        for (int v = 0; v < NVEC; v++) begin
            rst_n    = vecs[v].rst_n;
            lseon    = vecs[v].lseon;
            lsecsson = vecs[v].lsecsson;
            lse_rdy  = vecs[v].lse_rdy;
            if (vecs[v].restart) gen_phase = 0;
            gen_period = vecs[v].period;
            if (vecs[v].period == 0) lse_clk = vecs[v].lse_lvl;
            for (int t = 0; t < vecs[v].ticks; t++) begin
                tick();
                if (vecs[v].chk_all)
                    check3($sformatf("vec%0d_t%0d", v, t), vecs[v].exp_fail,
                           vecs[v].exp_int, vecs[v].exp_act);
            end
            if (!vecs[v].chk_all)
                check3($sformatf("vec%0d", v), vecs[v].exp_fail,
                       vecs[v].exp_int, vecs[v].exp_act);
            $display("vec %0d: fail=%b int=%b active=%b", v, lsecss_fail, lsecss_int, css_active);
        end

        // Stop detection in MONITOR: one rise, then frozen high
        arm_monitor("stop_arm");
        gen_period = 0;
        lse_clk    = 1'b0;
        repeat (10) tick();
        check3("stop_pre", 1'b0, 1'b0, 1'b1);
        lse_clk = 1'b1;
        for (int i = 1; i <= TIMEOUT + 6; i++) begin
            tick();
            chk($sformatf("stop_fail_t%0d", i), lsecss_fail, (i >= TIMEOUT + 3));
            chk($sformatf("stop_int_t%0d", i),  lsecss_int,  (i == TIMEOUT + 3));
        end
        $display("stop: fail=%b int=%b active=%b", lsecss_fail, lsecss_int, css_active);
        // LSE resumes: fail must stay
        gen_phase  = 0;
        gen_period = 20;
        repeat (100) tick();
        check3("stop_resume", 1'b1, 1'b0, 1'b0);
        $display("resume: fail=%b int=%b active=%b", lsecss_fail, lsecss_int, css_active);
        // One reset cycle out of FAIL
        rst_n = 1'b0;
        tick();
        check3("fail_rst", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        check3("fail_rst_after", 1'b0, 1'b0, 1'b0);
        $display("reset from fail: fail=%b int=%b active=%b", lsecss_fail, lsecss_int, css_active);

        // Gap boundary: edge on the last permitted cycle, then one cycle late
        boundary(TIMEOUT);
        boundary(TIMEOUT + 1);

        // Stop during arming: two edges, then frozen high
        do_reset();
        lseon    = 1'b1;
        lsecsson = 1'b1;
        lse_rdy  = 1'b1;
        lse_clk  = 1'b0;
        repeat (4) tick();
        for (int e = 0; e < 2; e++) begin
            lse_clk = (e == 1);
            for (int k = 0; k < 10; k++) begin
                tick();
                chk($sformatf("armstop_pre_active_%0d_%0d", e, k), css_active, 1'b0);
            end
            lse_clk = 1'b0;
            for (int k = 0; k < 10; k++) begin
                tick();
                chk($sformatf("armstop_low_active_%0d_%0d", e, k), css_active, 1'b0);
            end
        end
        // Edge count so far: only the e==1 rise. Add the second edge now and freeze.
        lse_clk = 1'b1;
        for (int i = 1; i <= TIMEOUT + 6; i++) begin
            tick();
            chk($sformatf("armstop_fail_t%0d", i),   lsecss_fail, (i >= TIMEOUT + 3));
            chk($sformatf("armstop_int_t%0d", i),    lsecss_int,  (i == TIMEOUT + 3));
            chk($sformatf("armstop_active_t%0d", i), css_active,  1'b0);
        end
        $display("arm stop: fail=%b int=%b active=%b", lsecss_fail, lsecss_int, css_active);

        // Reset while in MONITOR
        arm_monitor("monrst_arm");
        rst_n = 1'b0;
        tick();
        check3("monrst", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        $display("reset from monitor: fail=%b int=%b active=%b", lsecss_fail, lsecss_int, css_active);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
